// File: rtl/cam_timing_gen.sv
// Camera-style frame timing generator with vsync/href framing and a selectable test pattern.
// Define CAM_GEN_PATTERN_EN to enable the four-pattern mode select; otherwise only a ramp is produced.
module cam_timing_gen #(
    parameter int          H_VALID   = 640,
    parameter int          H_TOTAL   = 784,
    parameter int          V_SYNC    = 4,
    parameter int          V_BACK    = 18,
    parameter int          V_VALID   = 480,
    parameter int          V_TOTAL   = 510,
    parameter int          BPP       = 2,
    parameter logic [7:0]  CONST_VAL = 8'h80
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic [1:0]  mode,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BACK, S_ACTIVE, S_FRONT} state_t;

    localparam logic [15:0] H_LAST  = 16'(H_TOTAL * BPP - 1);
    localparam logic [15:0] H_ACT   = 16'(H_VALID * BPP);
    localparam logic [15:0] BPP_W   = 16'(BPP);
    localparam logic [15:0] VS_LAST = 16'(V_SYNC - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BACK - 1);
    localparam logic [15:0] VA_LAST = 16'(V_VALID - 1);
    localparam logic [15:0] VF_LAST = 16'(V_TOTAL - V_SYNC - V_BACK - V_VALID - 1);

    state_t      state, state_nx;
    logic [15:0] cnt_h, cnt_h_nx;
    logic [15:0] line_cnt, line_nx;
    logic [15:0] v_last;
    logic        line_end;
    logic        start_nx;
    logic        frame_done;
    logic        href_nx;
    logic [7:0]  ramp;
    logic [7:0]  data_nx;

    // Next-state values feed both the state registers and the output registers,
    // so vsync/href/data come out in the same cycle as the state they describe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_nx   = state;
        cnt_h_nx   = cnt_h;
        line_nx    = line_cnt;
        start_nx   = 1'b0;
        frame_done = 1'b0;
        line_end   = (cnt_h == H_LAST);
        v_last     = VF_LAST;
        case (state)
            S_SYNC:   v_last = VS_LAST;
            S_BACK:   v_last = VB_LAST;
            S_ACTIVE: v_last = VA_LAST;
            default:  v_last = VF_LAST;
        endcase

        if (state == S_IDLE) begin
            if (en) begin
                state_nx = S_SYNC;
                start_nx = 1'b1;
            end
        end else begin
            cnt_h_nx = line_end ? 16'd0 : cnt_h + 16'd1;
            if (line_end) begin
                if (line_cnt == v_last) begin
                    line_nx = 16'd0;
                    case (state)
                        S_SYNC:   state_nx = S_BACK;
                        S_BACK:   state_nx = S_ACTIVE;
                        S_ACTIVE: state_nx = S_FRONT;
                        default: begin
                            frame_done = 1'b1;
                            if (en) begin
                                state_nx = S_SYNC;
                                start_nx = 1'b1;
                            end else begin
                                state_nx = S_IDLE;
                            end
                        end
                    endcase
                end else begin
                    line_nx = line_cnt + 16'd1;
                end
            end
        end
    end

    assign href_nx = (state_nx == S_ACTIVE) && (cnt_h_nx < H_ACT);

`ifdef CAM_GEN_PATTERN_EN
    logic [1:0] mode_q;
    logic [3:0] pix_x_hi;   // pix_x[6:3]
    logic       pix_y_b3;

    assign pix_x_hi = 4'((cnt_h_nx / BPP_W) >> 3);
    assign pix_y_b3 = line_nx[3];

    // Mode is captured once per frame so a mid-frame change waits for the next frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q <= 2'd0;
        end else if (frame_start) begin
            mode_q <= mode;
        end
    end

    always_comb begin
        data_nx = 8'h00;
        if (href_nx) begin
            case (mode_q)
                2'd0:    data_nx = ramp;
                2'd1:    data_nx = {pix_x_hi[3:1], pix_x_hi[3:1], pix_x_hi[3:2]};
                2'd2:    data_nx = CONST_VAL;
                default: data_nx = (pix_x_hi[0] ^ pix_y_b3) ? 8'hFF : 8'h00;
            endcase
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ^mode;

    always_comb begin
        data_nx = 8'h00;
        if (href_nx) begin
            data_nx = ramp;
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            cnt_h       <= 16'd0;
            line_cnt    <= 16'd0;
            ramp        <= 8'd0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= 8'd0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state       <= state_nx;
            cnt_h       <= cnt_h_nx;
            line_cnt    <= line_nx;
            ramp        <= href_nx ? ramp + 8'd1 : 8'd0;
            cam_vsync   <= (state_nx == S_SYNC);
            cam_href    <= href_nx;
            cam_data    <= data_nx;
            frame_start <= start_nx;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_timing_gen.sv
// Directed bench for cam_timing_gen: a small-frame instance (A) and a wide-line instance (B, BPP=1).
// Expectations follow CAM_GEN_PATTERN_EN when the bench is built with it.
module tb_cam_timing_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        en;
    logic [1:0]  mode;

    logic        a_vsync, a_href, a_fs;
    logic [7:0]  a_data;
    logic [15:0] a_fcnt;
    logic        b_vsync, b_href, b_fs;
    logic [7:0]  b_data;
    logic [15:0] b_fcnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 sys_clk = ~sys_clk;

    cam_timing_gen #(
        .H_VALID(8), .H_TOTAL(12), .V_SYNC(2), .V_BACK(1), .V_VALID(4), .V_TOTAL(9), .BPP(2)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
        .cam_vsync(a_vsync), .cam_href(a_href), .cam_data(a_data),
        .frame_start(a_fs), .frame_cnt(a_fcnt)
    );

    cam_timing_gen #(
        .H_VALID(128), .H_TOTAL(136), .V_SYNC(1), .V_BACK(1), .V_VALID(2), .V_TOTAL(5), .BPP(1)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
        .cam_vsync(b_vsync), .cam_href(b_href), .cam_data(b_data),
        .frame_start(b_fs), .frame_cnt(b_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the falling edge after the next active edge.
    task automatic step();
        @(negedge sys_clk);
        cyc++;
    endtask

    // Reset both instances, then release with en=1; the next step() samples cycle 0.
    task automatic restart(input logic [1:0] m);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        en      = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        mode    = m;
        sys_rst = 1'b0;
        en      = 1'b1;
        @(posedge sys_clk);
        cyc = -1;
    endtask

    int xs [6] = '{0, 15, 16, 31, 112, 127};
`ifdef CAM_GEN_PATTERN_EN
    int bar_exp [6] = '{8'h00, 8'h00, 8'h24, 8'h24, 8'hFF, 8'hFF};
`else
    int bar_exp [6] = '{0, 15, 16, 31, 112, 127};
`endif

    initial begin
        int vs_cnt, href_cnt, first_href, fs_extra;

        // Reset dominates a pending run request.
        sys_rst = 1'b1;
        en      = 1'b1;
        mode    = 2'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_vsync", a_vsync, 0);
        check("rst_href",  a_href,  0);
        check("rst_data",  a_data,  0);
        check("rst_fs",    a_fs,    0);
        check("rst_fcnt",  a_fcnt,  0);
        check("rst_b_vs",  b_vsync, 0);

        // Basic frame timing with the ramp pattern.
        restart(2'd0);
        vs_cnt = 0; href_cnt = 0; first_href = -1; fs_extra = 0;
        while (cyc < 216) begin
            step();
            if (cyc == 0) begin
                check("s1_fs0", a_fs, 1);
                check("s1_vs0", a_vsync, 1);
            end
            if (cyc < 216) begin
                vs_cnt   += int'(a_vsync);
                href_cnt += int'(a_href);
                if (a_href && first_href < 0) first_href = cyc;
                if (cyc > 0 && a_fs) fs_extra++;
            end
            if (cyc >= 72 && cyc < 88) check($sformatf("s1_ramp%0d", cyc - 72), a_data, 32'(cyc - 72));
            if (cyc == 88) begin
                check("s1_href88", a_href, 0);
                check("s1_data88", a_data, 0);
            end
            if (cyc == 215) check("s1_fcnt215", a_fcnt, 0);
        end
        check("s1_vs_len",     32'(vs_cnt), 48);
        check("s1_first_href", 32'(first_href), 72);
        check("s1_href_total", 32'(href_cnt), 64);
        check("s1_fs_extra",   32'(fs_extra), 0);
        check("s1_fs216",      a_fs, 1);
        check("s1_fcnt216",    a_fcnt, 1);

        // Colour bars on B (ramp when the pattern select is compiled out, mode=2 ignored).
`ifdef CAM_GEN_PATTERN_EN
        restart(2'd1);
`else
        restart(2'd2);
`endif
        while (cyc < 400) begin
            step();
            if (cyc >= 72 && cyc < 88) begin
`ifdef CAM_GEN_PATTERN_EN
                check($sformatf("s2_a_bar%0d", cyc - 72), a_data, 0);
`else
                check($sformatf("s2_a_ramp%0d", cyc - 72), a_data, 32'(cyc - 72));
`endif
            end
            for (int k = 0; k < 6; k++) begin
                if (cyc == 272 + xs[k]) check($sformatf("s2_b_x%0d", xs[k]), b_data, 32'(bar_exp[k]));
            end
        end
        check("s2_b_href128", b_href, 0);
        check("s2_b_data128", b_data, 0);

        // Mode change mid-frame only lands on the next frame.
        restart(2'd0);
        while (cyc < 960) begin
            step();
            if (cyc == 280) check("s3_f0_l0_x8", b_data, 8);
            if (cyc == 300) mode = 2'd3;
            if (cyc == 416) check("s3_f0_l1_x8", b_data, 8);
            if (cyc == 680) begin
                check("s3_fs680", b_fs, 1);
                check("s3_fcnt680", b_fcnt, 1);
            end
            if (cyc == 959) begin
`ifdef CAM_GEN_PATTERN_EN
                check("s3_f1_x7", b_data, 8'h00);
`else
                check("s3_f1_x7", b_data, 7);
`endif
            end
        end
`ifdef CAM_GEN_PATTERN_EN
        check("s3_f1_x8", b_data, 8'hFF);
`else
        check("s3_f1_x8", b_data, 8);
`endif

        // Dropping en mid-frame lets the frame finish, then idles.
        restart(2'd0);
        while (cyc < 216) begin
            step();
            if (cyc == 100) en = 1'b0;
        end
        check("s4_fcnt",  a_fcnt,  1);
        check("s4_vsync", a_vsync, 0);
        check("s4_href",  a_href,  0);
        check("s4_data",  a_data,  0);
        check("s4_fs",    a_fs,    0);
        while (cyc < 236) step();
        check("s4_idle_vs",   a_vsync, 0);
        check("s4_idle_fcnt", a_fcnt,  1);

        // Reset pulse during href aborts the frame.
        restart(2'd0);
        while (cyc < 80) step();
        check("s5_href80", a_href, 1);
        check("s5_data80", a_data, 8);
        sys_rst = 1'b1;
        step();
        check("s5_href", a_href, 0);
        check("s5_data", a_data, 0);
        check("s5_fcnt", a_fcnt, 0);
        check("s5_vs",   a_vsync, 0);
        sys_rst = 1'b0;
        step();
        check("s5_restart_fs", a_fs, 1);
        check("s5_restart_vs", a_vsync, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cam_timing_gen.md
CAM_TIMING_GEN -- requirements
Module: cam_timing_gen

Interface
REQ-001 The block SHALL have the parameter H_VALID, default 640, meaning active pixels per line.
REQ-002 The block SHALL have the parameter H_TOTAL, default 784, meaning total pixel periods per line.
REQ-003 The block SHALL have the parameter V_SYNC, default 4, meaning vsync lines.
REQ-004 The block SHALL have the parameter V_BACK, default 18, meaning back-porch lines.
REQ-005 The block SHALL have the parameter V_VALID, default 480, meaning active lines.
REQ-006 The block SHALL have the parameter V_TOTAL, default 510, meaning total lines per frame; front porch = V_TOTAL-V_SYNC-V_BACK-V_VALID.
REQ-007 The block SHALL have the parameter BPP, default 2, meaning bytes per pixel (1 or 2), one byte per clock.
REQ-008 The block SHALL have the parameter CONST_VAL, default 8'h80, meaning the byte value used in constant mode.
REQ-009 sys_clk  in  1  single clock; one byte period per cycle.
REQ-010 sys_rst  in  1  reset; synchronous, active-high.
REQ-011 en  in  1  run request.
REQ-012 mode  in  2  pattern select: 0 ramp, 1 colour bars, 2 constant, 3 checkerboard.
REQ-013 cam_vsync  out  1  frame sync.
REQ-014 cam_href  out  1  line-valid.
REQ-015 cam_data  out  8  pixel byte.
REQ-016 frame_start  out  1  one-cycle pulse on the first SYNC cycle of each frame.
REQ-017 frame_cnt  out  16  completed-frame count.

Function
REQ-018 The vertical FSM SHALL have the states IDLE, SYNC, BACK, ACTIVE, FRONT.
REQ-019 IDLE->SYNC SHALL occur when en=1; SYNC->BACK after V_SYNC lines; BACK->ACTIVE after V_BACK lines; ACTIVE->FRONT after V_VALID lines; FRONT->SYNC after the last front line if en=1, else FRONT->IDLE.
REQ-020 The horizontal counter cnt_h SHALL run 0..H_TOTAL*BPP-1 and wrap to 0, and SHALL advance only outside IDLE; a line ends when cnt_h wraps.
REQ-021 cam_vsync SHALL be 1 for exactly the state SYNC.
REQ-022 cam_href SHALL be 1 iff the state is ACTIVE and cnt_h < H_VALID*BPP.
REQ-023 The pixel column pix_x SHALL equal cnt_h/BPP, and the active line index pix_y SHALL be 0..V_VALID-1.
REQ-024 In mode 0 (ramp), cam_data SHALL be cleared to 0 outside href and SHALL increment by 1 per href cycle, wrapping modulo 256.
REQ-025 In mode 1 (colour bars), cam_data SHALL be {pix_x[6:4], pix_x[6:4], pix_x[6:5]}.
REQ-026 In mode 2 (constant), cam_data SHALL be CONST_VAL.
REQ-027 In mode 3 (checkerboard), cam_data SHALL be 8'hFF if pix_x[3]^pix_y[3], else 8'h00.
REQ-028 cam_data SHALL be 0 whenever href=0, in every mode.
REQ-029 mode SHALL be sampled only on the frame_start cycle; a mid-frame change SHALL take effect on the next frame.
REQ-030 cam_vsync, cam_href and cam_data SHALL be registered and mutually aligned (same cycle).
REQ-031 Deasserting en mid-frame SHALL NOT truncate the frame: the frame completes through FRONT, then the FSM goes to IDLE.
REQ-032 frame_cnt SHALL increment on the FRONT->SYNC/IDLE transition and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-033 sys_rst=1 at a sys_clk edge SHALL force IDLE, cnt_h=0, line counter=0, all outputs 0, and the latched mode=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_cnt increment.

Configuration
REQ-035 With CAM_GEN_PATTERN_EN defined, all four modes SHALL be supported.
REQ-036 Without CAM_GEN_PATTERN_EN, mode SHALL be ignored, ramp only SHALL be produced, and the mode latch SHALL be omitted.

Verification (H_VALID=8, H_TOTAL=12, V_SYNC=2, V_BACK=1, V_VALID=4, V_TOTAL=9, BPP=2)
REQ-037 Scenario: reset release, en=1, mode=0 -> frame_start on the first cycle; vsync high 48 cycles; href first high at cycle 72 for 16 cycles, with data 0..15; frame period 216 cycles.
REQ-038 Scenario: mode=1, H_VALID=128, BPP=1 -> data 8'h00 for x 0..15, 8'h24 for x 16..31, 8'hFF for x 112..127.
REQ-039 Scenario: mode changed 0->3 mid-ACTIVE -> the current frame stays ramp; the next frame is checkerboard with line 0 at x=8 giving 8'hFF.
REQ-040 Scenario: en dropped at cycle 100 -> the frame completes at cycle 216, frame_cnt=1, FSM in IDLE, all outputs 0.
REQ-041 Scenario: sys_rst pulsed at cycle 80 (during href) -> next cycle href=0, data=0, frame_cnt=0; restart yields frame_start.
REQ-042 Scenario: macro undefined, mode=2 -> ramp data 0..15 observed.
